// File: rtl/adc_ad4003_ctrl.sv
// ----------------------------------------------------------------------------
// adc_ad4003_ctrl
//
// Conversion sequencer for an AD4003 SAR ADC. Each sample period asserts CNV
// for the conversion time, then opens a window that enables the downstream
// 2-channel SDO shift register for ADC_DATA_WIDTH clocks. After a settling
// delay it issues a single-clock data_valid and counts the completed sample.
// Sampling repeats at a fixed period while acq_en stays high.
//
// Parameters
//   ADC_DATA_WIDTH : SDO bits per conversion (length of the reader_en window)
//   CONV_CYCLES    : adc_cnv high time in clocks
//   LATCH_DELAY    : clocks from the last read bit to data_valid (inclusive)
//   PERIOD_CYCLES  : sample period in clocks,
//                    >= CONV_CYCLES + ADC_DATA_WIDTH + LATCH_DELAY
//
// Ports
//   adc_clk    in   system clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   acq_en     in   acquisition enable (level)
//   adc_cnv    out  AD4003 CNV drive
//   reader_en  out  SDO shift-register enable window
//   data_valid out  one-clock pulse, shift-register holds a complete sample
//   sample_cnt out  completed-sample count, wraps silently
//   busy       out  high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module adc_ad4003_ctrl #(
    parameter int ADC_DATA_WIDTH = 18,
    parameter int CONV_CYCLES    = 24,
    parameter int LATCH_DELAY    = 4,
    parameter int PERIOD_CYCLES  = 80
) (
    input  logic        adc_clk,
    input  logic        rst,
    input  logic        acq_en,
    output logic        adc_cnv,
    output logic        reader_en,
    output logic        data_valid,
    output logic [31:0] sample_cnt,
    output logic        busy
);

    localparam int MAX_AB = (ADC_DATA_WIDTH > CONV_CYCLES) ? ADC_DATA_WIDTH : CONV_CYCLES;
    localparam int MAX_CD = (LATCH_DELAY > PERIOD_CYCLES) ? LATCH_DELAY : PERIOD_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(ADC_DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST  = CNT_W'(LATCH_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic             LATCH_ONE   = (LATCH_DELAY == 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_READ  = 3'd2,
        ST_LATCH = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   period_cnt_r;
    logic [CNT_W-1:0]   phase_r;
    logic               adc_cnv_r;
    logic               reader_en_r;
    logic               data_valid_r;
    logic               busy_r;
    logic [31:0]        sample_cnt_r;

    // Sequencer: state, period/phase counters and all registered outputs.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            period_cnt_r <= '0;
            phase_r      <= '0;
            adc_cnv_r    <= 1'b0;
            reader_en_r  <= 1'b0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            sample_cnt_r <= 32'd0;
        end else begin
            // data_valid is a strobe; only the edge entering the last LATCH
            // clock raises it.
            data_valid_r <= 1'b0;

            // Period counter is frozen at 0 while idle so the first CONV clock
            // of every acquisition run sits at period offset 0.
            if ((state_r == ST_IDLE) || (period_cnt_r == PERIOD_LAST)) begin
                period_cnt_r <= '0;
            end else begin
                period_cnt_r <= period_cnt_r + CNT_W'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    phase_r     <= '0;
                    reader_en_r <= 1'b0;
                    if (acq_en) begin
                        state_r   <= ST_CONV;
                        adc_cnv_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        adc_cnv_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end

                ST_CONV: begin
                    if (phase_r == CONV_LAST) begin
                        state_r     <= ST_READ;
                        phase_r     <= '0;
                        adc_cnv_r   <= 1'b0;
                        reader_en_r <= 1'b1;
                    end else begin
                        phase_r <= phase_r + CNT_W'(1);
                    end
                end

                ST_READ: begin
                    if (phase_r == READ_LAST) begin
                        state_r     <= ST_LATCH;
                        phase_r     <= '0;
                        reader_en_r <= 1'b0;
                        // A one-clock LATCH is its own last clock.
                        if (LATCH_ONE) begin
                            data_valid_r <= 1'b1;
                            sample_cnt_r <= sample_cnt_r + 32'd1;
                        end else begin
                            data_valid_r <= 1'b0;
                        end
                    end else begin
                        phase_r <= phase_r + CNT_W'(1);
                    end
                end

                ST_LATCH: begin
                    if (phase_r == LATCH_LAST) begin
                        phase_r <= '0;
                        // With a minimum-length period the sample ends exactly
                        // on the period boundary, so WAIT is skipped and the
                        // restart decision is taken here.
                        if (period_cnt_r == PERIOD_LAST) begin
                            if (acq_en) begin
                                state_r   <= ST_CONV;
                                adc_cnv_r <= 1'b1;
                            end else begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        phase_r <= phase_r + CNT_W'(1);
                        if ((phase_r + CNT_W'(1)) == LATCH_LAST) begin
                            data_valid_r <= 1'b1;
                            sample_cnt_r <= sample_cnt_r + 32'd1;
                        end else begin
                            data_valid_r <= 1'b0;
                        end
                    end
                end

                ST_WAIT: begin
                    phase_r <= '0;
                    if (period_cnt_r == PERIOD_LAST) begin
                        if (acq_en) begin
                            state_r   <= ST_CONV;
                            adc_cnv_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end

                default: begin
                    state_r      <= ST_IDLE;
                    phase_r      <= '0;
                    adc_cnv_r    <= 1'b0;
                    reader_en_r  <= 1'b0;
                    data_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign adc_cnv    = adc_cnv_r;
    assign reader_en  = reader_en_r;
    assign data_valid = data_valid_r;
    assign sample_cnt = sample_cnt_r;
    assign busy       = busy_r;

endmodule
